instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the single-issue RISC-V core. Owns the program counter, drives the combinational program memory's word address, and captures the returned 32-bit instruction into the IF/ID pipeline register with a valid/ready handshake toward decode. It handles branch/jump redirects and halts fetch on EBREAK.

## Interface

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013, value held on if_instruction whenever if_valid is 0 (ADDI x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_address  out  32  byte address to program memory; equals pc combinationally.
- imem_instruction  in  32  instruction word from program memory, already in register bit order; valid in the same cycle as imem_address.
- redirect_valid  in  1  control-flow change from execute (taken branch, JAL, JALR).
- redirect_target  in  32  new PC; bits [1:0] ignored (treated as 00).
- if_valid  out  1  IF/ID register holds a real instruction.
- if_ready  in  1  decode accepts the IF/ID contents this cycle.
- if_pc  out  32  address of the instruction in IF/ID.
- if_instruction  out  32  instruction in IF/ID.
- halted  out  1  fetch stopped after an EBREAK.

## Operation

- Internal state: pc (32 b), IF/ID register {if_valid, if_pc, if_instruction}, FSM state.
- FSM states: BOOT, RUN, HALTED.
  - BOOT: entered on reset; lasts exactly one cycle; no capture; moves to RUN.
  - RUN: fetch active.
  - HALTED: entered when an EBREAK (32'h0010_0073) is captured into IF/ID; no further captures; pc frozen at EBREAK address + 4. Left only via redirect_valid (→ RUN) or reset.
- Advance condition: adv = (state == RUN) && (!if_valid || if_ready).
- Per cycle, priority high to low:
  1. reset: pc ← RESET_VECTOR, if_valid ← 0, if_pc ← 0, if_instruction ← NOP_INSTR, state ← BOOT.
  2. redirect_valid: pc ← {redirect_target[31:2], 2'b00}; if_valid ← 0 (flushes IF/ID regardless of if_ready); if_instruction ← NOP_INSTR; state ← RUN (also from BOOT or HALTED).
  3. adv: if_valid ← 1, if_pc ← pc, if_instruction ← imem_instruction, pc ← pc + 4; if captured word is EBREAK, state ← HALTED.
  4. if_valid && if_ready && !adv (only in BOOT/HALTED): if_valid ← 0, if_instruction ← NOP_INSTR.
  5. otherwise hold all state (stall).
- pc arithmetic: unsigned 32-bit, modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000. No alignment or range checking beyond forcing [1:0] = 0.
- While if_valid = 1 and if_ready = 0, if_pc and if_instruction are stable.
- halted = (state == HALTED), registered.

## Timing

- Reset values: imem_address = RESET_VECTOR, if_valid = 0, if_pc = 0, if_instruction = NOP_INSTR, halted = 0.
- First cycle after reset released: BOOT, no capture. Second cycle: RUN, capture at end; if_valid = 1 with if_pc = RESET_VECTOR in the third cycle.
- Fetch-to-IF/ID latency: 1 cycle. Throughput: 1 instruction/cycle with if_ready held 1.
- Redirect penalty: redirect in cycle N → cycle N+1 shows if_valid = 0 and imem_address = target; target instruction visible on IF/ID in cycle N+2.
- redirect_valid and if_ready both high in one cycle: decode consumes current IF/ID; IF/ID still becomes empty; no capture.
- redirect_valid in the same cycle an EBREAK would be captured: redirect wins; no HALTED entry.
- Reset mid-stall or mid-halt: reset values apply next cycle; pending IF/ID contents are discarded.

## Test plan

- Reset, RESET_VECTOR = 0, memory words 0..3 = distinct ADDIs, if_ready = 1: if_pc sequence 0, 4, 8, 12 from the third cycle, one per cycle; if_valid low for the first two cycles.
- Stall: hold if_ready = 0 for 3 cycles while if_pc = 8: if_pc/if_instruction stable, imem_address stays 12; release → if_pc = 12 next cycle.
- Redirect: assert redirect_valid with target 32'h0000_0042 while if_valid = 1, if_ready = 0: next cycle if_valid = 0, if_instruction = 32'h0000_0013, imem_address = 32'h0000_0040; cycle after, if_pc = 32'h40.
- EBREAK at address 0x10: captured with if_pc = 0x10, halted = 1 the following cycle, imem_address frozen at 0x14, if_valid drops after decode accepts; redirect to 0x0 → halted = 0, fetch resumes at 0.
- Wrap: RESET_VECTOR = 32'hFFFF_FFFC: if_pc 32'hFFFF_FFFC then 32'h0000_0000.
- Reset asserted during stall with if_valid = 1: next cycle if_valid = 0, halted = 0, imem_address = RESET_VECTOR.

Source files
------------

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage of the single-issue RISC-V core. Owns the program counter and
// drives the combinational program memory address. Captures the returned word
// into the IF/ID register, using a valid/ready handshake toward decode.
// Handles execute-stage redirects and stops fetching after an EBREAK.
//
// Ports
//   clk               in   1   rising-edge clock
//   reset             in   1   synchronous, active-high reset
//   imem_address      out  32  byte address to program memory (= pc)
//   imem_instruction  in  32  instruction word for imem_address, same cycle
//   redirect_valid    in   1  control-flow change from execute
//   redirect_target   in  32  new pc, bits [1:0] forced to 0
//   if_valid          out  1  IF/ID holds a real instruction
//   if_ready          in   1  decode accepts IF/ID this cycle
//   if_pc             out 32  address of the instruction in IF/ID
//   if_instruction    out 32  instruction in IF/ID (NOP_INSTR when not valid)
//   halted            out  1  fetch stopped after an EBREAK
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        halted
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [XLEN-1:0] PC_STEP      = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   if_pc_q, if_pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              halted_q, halted_d;
  logic              adv_c;

  // State register: pc, IF/ID register, FSM state and halted flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_VECTOR;
      valid_q  <= 1'b0;
      if_pc_q  <= '0;
      instr_q  <= NOP_INSTR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      if_pc_q  <= if_pc_d;
      instr_q  <= instr_d;
      halted_q <= halted_d;
    end
  end

  // A new word may enter IF/ID only while running and IF/ID is free or draining.
  assign adv_c = (state_q == ST_RUN) && (!valid_q || if_ready);

  // Next-state logic; redirect outranks capture, capture outranks drain.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if_pc_d = if_pc_q;
    instr_d = instr_q;

    if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
    end

    if (redirect_valid) begin
      // Flush IF/ID even if decode is consuming it this cycle.
      pc_d    = redirect_target & ALIGN_MASK;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      state_d = ST_RUN;
    end else if (adv_c) begin
      valid_d = 1'b1;
      if_pc_d = pc_q;
      instr_d = imem_instruction;
      pc_d    = pc_q + PC_STEP;
      if (imem_instruction == EBREAK_INSTR) begin
        state_d = ST_HALTED;
      end
    end else if (valid_q && if_ready) begin
      // Decode drains IF/ID while fetch is not running (BOOT/HALTED).
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    halted_d = (state_d == ST_HALTED);
  end

  assign imem_address   = pc_q;
  assign if_valid       = valid_q;
  assign if_pc          = if_pc_q;
  assign if_instruction = instr_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch. u_dut runs a small program from
// address 0. u_wrap starts at 32'hFFFF_FFFC to exercise pc wrap-around.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        halted;

  logic [31:0] w_imem_address;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_instruction;
  logic        w_halted;

  logic [31:0] mem [32];

  int total;
  int bad;

  instruction_fetch #(
    .RESET_VECTOR(32'h0000_0000),
    .NOP_INSTR   (NOP)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .imem_address    (imem_address),
    .imem_instruction(imem_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instruction  (if_instruction),
    .halted          (halted)
  );

  instruction_fetch #(
    .RESET_VECTOR(32'hFFFF_FFFC),
    .NOP_INSTR   (NOP)
  ) u_wrap (
    .clk             (clk),
    .reset           (reset),
    .imem_address    (w_imem_address),
    .imem_instruction(NOP),
    .redirect_valid  (1'b0),
    .redirect_target (32'h0000_0000),
    .if_valid        (w_if_valid),
    .if_ready        (1'b1),
    .if_pc           (w_if_pc),
    .if_instruction  (w_if_instruction),
    .halted          (w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational program memory, 32 words; NOP outside that range.
  always_comb begin
    if (imem_address[31:7] == 25'd0) imem_instruction = mem[imem_address[6:2]];
    else                              imem_instruction = NOP;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) mem[i] = NOP;
    mem[0]  = 32'h0010_0093;
    mem[1]  = 32'h0020_0113;
    mem[2]  = 32'h0030_0193;
    mem[3]  = 32'h0040_0213;
    mem[4]  = EBREAK;
    mem[16] = 32'h0050_0293;
    mem[17] = 32'h0060_0313;

    reset           = 1'b1;
    if_ready        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    @(negedge clk);
    tick();

    // Reset values
    check_eq("rst_imem",   imem_address, 32'h0);
    check_eq("rst_valid",  32'(if_valid), 32'd0);
    check_eq("rst_pc",     if_pc, 32'h0);
    check_eq("rst_instr",  if_instruction, NOP);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_wimem",  w_imem_address, 32'hFFFF_FFFC);

    // BOOT cycle: no capture
    reset = 1'b0;
    tick();
    check_eq("boot_valid", 32'(if_valid), 32'd0);
    check_eq("boot_imem",  imem_address, 32'h0);

    // Streaming at one instruction per cycle
    tick();
    check_eq("s0_valid", 32'(if_valid), 32'd1);
    check_eq("s0_pc",    if_pc, 32'h0);
    check_eq("s0_instr", if_instruction, 32'h0010_0093);
    check_eq("s0_imem",  imem_address, 32'h4);
    check_eq("w0_pc",    w_if_pc, 32'hFFFF_FFFC);
    check_eq("w0_imem",  w_imem_address, 32'h0);
    tick();
    check_eq("s1_pc",    if_pc, 32'h4);
    check_eq("s1_instr", if_instruction, 32'h0020_0113);
    check_eq("w1_pc",    w_if_pc, 32'h0);
    check_eq("w1_valid", 32'(w_if_valid), 32'd1);
    tick();
    check_eq("s2_pc",    if_pc, 32'h8);

    // Stall for three cycles at if_pc = 8
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_pc",    if_pc, 32'h8);
      check_eq("stall_instr", if_instruction, 32'h0030_0193);
      check_eq("stall_imem",  imem_address, 32'hC);
      check_eq("stall_valid", 32'(if_valid), 32'd1);
    end
    if_ready = 1'b1;
    tick();
    check_eq("rel_pc",    if_pc, 32'hC);
    check_eq("rel_instr", if_instruction, 32'h0040_0213);
    check_eq("rel_imem",  imem_address, 32'h10);

    // Redirect to an unaligned target while decode stalls
    if_ready        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0042;
    tick();
    check_eq("rd_valid", 32'(if_valid), 32'd0);
    check_eq("rd_instr", if_instruction, NOP);
    check_eq("rd_imem",  imem_address, 32'h40);
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    tick();
    check_eq("rd_pc",    if_pc, 32'h40);
    check_eq("rd_tinst", if_instruction, 32'h0050_0293);
    check_eq("rd_tval",  32'(if_valid), 32'd1);

    // Redirect to the EBREAK, with decode accepting in the same cycle
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0010;
    tick();
    check_eq("rb_valid", 32'(if_valid), 32'd0);
    check_eq("rb_imem",  imem_address, 32'h10);
    redirect_valid = 1'b0;
    tick();
    check_eq("eb_pc",     if_pc, 32'h10);
    check_eq("eb_instr",  if_instruction, EBREAK);
    check_eq("eb_halted", 32'(halted), 32'd1);
    check_eq("eb_imem",   imem_address, 32'h14);
    if_ready = 1'b0;
    tick();
    check_eq("eb_hold_valid", 32'(if_valid), 32'd1);
    check_eq("eb_hold_imem",  imem_address, 32'h14);
    if_ready = 1'b1;
    tick();
    check_eq("eb_drain_valid", 32'(if_valid), 32'd0);
    check_eq("eb_drain_instr", if_instruction, NOP);
    check_eq("eb_drain_halt",  32'(halted), 32'd1);
    tick();
    check_eq("eb_idle_valid", 32'(if_valid), 32'd0);
    check_eq("eb_idle_imem",  imem_address, 32'h14);

    // Redirect out of HALTED
    redirect_valid  = 1'b1;
    redirect_target = 32'h0;
    tick();
    check_eq("rs_halted", 32'(halted), 32'd0);
    check_eq("rs_imem",   imem_address, 32'h0);
    check_eq("rs_valid",  32'(if_valid), 32'd0);
    redirect_valid = 1'b0;
    tick();
    check_eq("rs_pc",    if_pc, 32'h0);
    check_eq("rs_instr", if_instruction, 32'h0010_0093);
    tick();
    tick();
    tick();
    check_eq("rs3_pc",   if_pc, 32'hC);
    check_eq("rs3_imem", imem_address, 32'h10);

    // Redirect in the same cycle that EBREAK would be captured
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick();
    check_eq("rx_halted", 32'(halted), 32'd0);
    check_eq("rx_valid",  32'(if_valid), 32'd0);
    check_eq("rx_imem",   imem_address, 32'h40);
    redirect_valid = 1'b0;
    tick();
    check_eq("rx_pc", if_pc, 32'h40);

    // Reset during a stall with IF/ID occupied
    if_ready = 1'b0;
    tick();
    check_eq("rm_valid_pre", 32'(if_valid), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("rm_valid",  32'(if_valid), 32'd0);
    check_eq("rm_halted", 32'(halted), 32'd0);
    check_eq("rm_imem",   imem_address, 32'h0);
    check_eq("rm_pc",     if_pc, 32'h0);
    check_eq("rm_instr",  if_instruction, NOP);
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
